// File: rtl/mem_pkg.sv
// Shared types and constants for the block refill / write-back controller.
package mem_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Default block geometry (32-bit words, four words per block).
  localparam int PKG_DATA_WIDTH      = 32;
  localparam int PKG_WORDS_PER_BLOCK = 4;
  localparam int BLOCK_BYTES         = PKG_WORDS_PER_BLOCK * 4;
  localparam int OFFSET_BITS         = $clog2(BLOCK_BYTES);

  // One cache block, word 0 in the LSBs.
  typedef logic [PKG_WORDS_PER_BLOCK*PKG_DATA_WIDTH-1:0] block_t;

  // Number of byte-offset bits inside a block of the given word count.
  function automatic int offset_bits_of(input int words);
    return $clog2(words * 4);
  endfunction

endpackage

// File: rtl/mem_beat_ctr.sv
// Beat index plus wait-state counter. A beat lasts 1+WAIT_STATES cycles;
// clear has priority over enable and returns both counters to zero.
module mem_beat_ctr #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int WAIT_STATES     = 0,
  parameter int BEAT_W          = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [BEAT_W-1:0] beat,
  output logic              beat_last_cycle,
  output logic              beat_done
);

  logic [BEAT_W-1:0] beat_reg;

  if (WAIT_STATES == 0) begin : g_no_wait
    assign beat_last_cycle = 1'b1;
  end else begin : g_wait
    localparam int WAIT_W = $clog2(WAIT_STATES + 1);
    logic [WAIT_W-1:0] wait_reg;

    // Count cycles inside the current beat, restarting on each new beat.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        wait_reg <= '0;
      end else if (enable) begin
        wait_reg <= (wait_reg == WAIT_W'(WAIT_STATES)) ? '0 : wait_reg + 1'b1;
      end
    end

    assign beat_last_cycle = (wait_reg == WAIT_W'(WAIT_STATES));
  end

  // Advance the beat index on the final cycle of each beat.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_reg <= '0;
    end else if (enable && beat_last_cycle) begin
      beat_reg <= beat_reg + 1'b1;
    end
  end

  assign beat      = beat_reg;
  assign beat_done = beat_last_cycle && (beat_reg == BEAT_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/mem_block_ctrl.sv
// Memory-side responder for the data cache block interface: optional dirty
// write-back followed by a block fetch, serialised onto a one-word RAM port.
// Optional macro MEM_WAIT_STATES_EN stretches every beat to 1+WAIT_STATES
// cycles and turns the fetch into a non-pipelined read.
module mem_block_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int WAIT_STATES     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_wb,
  input  logic [ADDR_WIDTH-1:0]                 req_wb_addr,
  input  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] req_wb_data,
  input  logic [ADDR_WIDTH-1:0]                 req_fetch_addr,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] resp_data,
  output logic                                  busy,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic                                  mem_wr_en,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int IDX_W    = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int BEAT_W   = IDX_W + 1;
  localparam int OFF_BITS = offset_bits_of(WORDS_PER_BLOCK);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
`ifdef MEM_WAIT_STATES_EN
  localparam int EFF_WAIT = WAIT_STATES;
`else
  localparam int EFF_WAIT = 0 * WAIT_STATES;
`endif

  state_t state_reg, state_next;
  logic   ctr_clear, ctr_enable;
  logic   fetch_done;
  logic [BEAT_W-1:0] beat;
  logic [IDX_W-1:0]  beat_idx;
  logic              beat_last_cycle, beat_done;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [ADDR_WIDTH-1:0] wb_base_reg, fetch_base_reg;
  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] wb_data_reg, resp_data_reg;
  logic [WORDS_PER_BLOCK-1:0] cap_vec;

  mem_beat_ctr #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .WAIT_STATES     (EFF_WAIT),
    .BEAT_W          (BEAT_W)
  ) u_beat_ctr (
    .clk             (clk),
    .rst             (rst),
    .clear           (ctr_clear),
    .enable          (ctr_enable),
    .beat            (beat),
    .beat_last_cycle (beat_last_cycle),
    .beat_done       (beat_done)
  );

  assign beat_idx = beat[IDX_W-1:0];
  assign word_off = ADDR_WIDTH'(beat) << 2;

`ifdef MEM_WAIT_STATES_EN
  // Each read beat captures its own word, so the last beat ends the fetch.
  assign fetch_done = beat_done;
`else
  // Pipelined read: one trailing count collects the final word.
  assign fetch_done = (beat == BEAT_W'(WORDS_PER_BLOCK));
`endif

  // Next-state logic; every transition also clears the beat counter.
  always_comb begin
    state_next = state_reg;
    ctr_clear  = 1'b0;
    ctr_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = req_wb ? WB : FETCH;
          ctr_clear  = 1'b1;
        end
      end
      WB: begin
        ctr_enable = 1'b1;
        if (beat_done) begin
          state_next = FETCH;
          ctr_clear  = 1'b1;
        end
      end
      FETCH: begin
        ctr_enable = 1'b1;
        if (fetch_done) begin
          state_next = RESP;
          ctr_clear  = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
          ctr_clear  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ctr_clear  = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch block bases and write-back data when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_base_reg    <= '0;
      fetch_base_reg <= '0;
      wb_data_reg    <= '0;
    end else if (state_reg == IDLE && req_valid) begin
      wb_base_reg    <= req_wb_addr & BASE_MASK;
      fetch_base_reg <= req_fetch_addr & BASE_MASK;
      wb_data_reg    <= req_wb_data;
    end
  end

  // Per-word capture strobes for the response block.
  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_cap
`ifdef MEM_WAIT_STATES_EN
    assign cap_vec[gi] = (state_reg == FETCH) && beat_last_cycle &&
                         (beat == BEAT_W'(gi));
`else
    assign cap_vec[gi] = (state_reg == FETCH) && (beat == BEAT_W'(gi + 1));
`endif
  end

  // Response block register; holds until the next fetch overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data_reg <= '0;
    end else begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        if (cap_vec[i]) begin
          resp_data_reg[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
        end
      end
    end
  end

  // RAM port drive; the write strobe is cut by reset so an abort issues no write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    case (state_reg)
      WB: begin
        mem_addr  = wb_base_reg + word_off;
        mem_wdata = wb_data_reg[beat_idx*DATA_WIDTH +: DATA_WIDTH];
        mem_wr_en = beat_last_cycle && !rst;
      end
      FETCH: begin
        if (beat < BEAT_W'(WORDS_PER_BLOCK)) begin
          mem_addr = fetch_base_reg + word_off;
        end
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign req_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl with a word-wide RAM model.
module tb_mem_block_ctrl;
  import mem_pkg::*;

`ifdef MEM_WAIT_STATES_EN
  localparam int BEAT   = 3;
  localparam int LAT_F  = 13;
  localparam int LAT_WB = 25;
`else
  localparam int BEAT   = 1;
  localparam int LAT_F  = 6;
  localparam int LAT_WB = 10;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wb = 1'b0;
  logic [31:0]  req_wb_addr = '0;
  block_t       req_wb_data = '0;
  logic [31:0]  req_fetch_addr = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  block_t       resp_data;
  logic         busy;
  logic [31:0]  mem_addr;
  logic         mem_wr_en;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         ram_init = 1'b1;
  logic [31:0]  ram [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_block_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wb         (req_wb),
    .req_wb_addr    (req_wb_addr),
    .req_wb_data    (req_wb_data),
    .req_fetch_addr (req_fetch_addr),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .busy           (busy),
    .mem_addr       (mem_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Backing RAM: registered read, write on the clock edge, preload on ram_init.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram[10'h040] <= 32'h11;
      ram[10'h041] <= 32'h22;
      ram[10'h042] <= 32'h33;
      ram[10'h043] <= 32'h44;
      for (int i = 0; i < 4; i++) ram[10'h100 + i] <= 32'hDEAD0000 + i;
    end else if (mem_wr_en) begin
      ram[mem_addr[11:2]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[11:2]];
  end

  typedef struct {
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] fetch_addr;
    block_t      wb_data;
    block_t      exp_data;
    int          exp_lat;
    int          hold;
    logic        early_rr;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " req_ready"}, req_ready, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " resp_valid"}, resp_valid, 1'b0);
    check({tag, " mem_wr_en"}, mem_wr_en, 1'b0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic [31:0] wb_base, f_base;
    int c, wb_cyc;
    logic exp_we;
    v = vecs[idx];
    wb_base = v.wb_addr & ~32'hF;
    f_base  = v.fetch_addr & ~32'hF;
    wb_cyc  = v.wb ? 4 * BEAT : 0;
    req_wb = v.wb; req_wb_addr = v.wb_addr; req_wb_data = v.wb_data;
    req_fetch_addr = v.fetch_addr; req_valid = 1'b1;
    check($sformatf("v%0d accept ready", idx), req_ready, 1'b1);
    tick();
    // Request inputs become don't-care after acceptance.
    req_valid = 1'b0; req_wb_data = '1; req_wb_addr = '1; req_fetch_addr = '1;
    resp_ready = v.early_rr;
    c = 1;
    while (resp_valid !== 1'b1 && c < 60) begin
      check($sformatf("v%0d c%0d busy", idx, c), busy, 1'b1);
      check($sformatf("v%0d c%0d req_ready", idx, c), req_ready, 1'b0);
      exp_we = (c <= wb_cyc) && (((c - 1) % BEAT) == BEAT - 1);
      check($sformatf("v%0d c%0d wr_en", idx, c), mem_wr_en, exp_we);
      if (c <= wb_cyc) begin
        check($sformatf("v%0d c%0d wb addr", idx, c), mem_addr,
              wb_base + 32'(4 * ((c - 1) / BEAT)));
        if (exp_we)
          check($sformatf("v%0d c%0d wdata", idx, c), mem_wdata,
                v.wb_data[((c - 1) / BEAT) * 32 +: 32]);
      end else if (c <= wb_cyc + 4 * BEAT) begin
        check($sformatf("v%0d c%0d fetch addr", idx, c), mem_addr,
              f_base + 32'(4 * ((c - wb_cyc - 1) / BEAT)));
      end
      tick();
      c++;
    end
    check($sformatf("v%0d resp_valid", idx), resp_valid, 1'b1);
    check($sformatf("v%0d latency", idx), c, v.exp_lat);
    check($sformatf("v%0d resp_data", idx), resp_data, v.exp_data);
    $display("txn %0d: wb=%0b fetch=%h latency=%0d data=%h", idx, v.wb, v.fetch_addr, c, resp_data);
    // Backpressure with a competing request that must not be accepted.
    if (v.hold > 0) begin
      req_valid = 1'b1; req_wb = 1'b1; req_wb_addr = 32'h100; req_fetch_addr = 32'h200;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        check($sformatf("v%0d hold%0d resp_valid", idx, h), resp_valid, 1'b1);
        check($sformatf("v%0d hold%0d resp_data", idx, h), resp_data, v.exp_data);
        check($sformatf("v%0d hold%0d req_ready", idx, h), req_ready, 1'b0);
        check($sformatf("v%0d hold%0d wr_en", idx, h), mem_wr_en, 1'b0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_idle($sformatf("v%0d after resp", idx));
    check($sformatf("v%0d data held", idx), resp_data, v.exp_data);
    tick();
    check_idle($sformatf("v%0d idle", idx));
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{wb: 1'b0, wb_addr: 32'h0, fetch_addr: 32'h108, wb_data: '0,
                exp_data: 128'h00000044_00000033_00000022_00000011,
                exp_lat: LAT_F, hold: 0, early_rr: 1'b0};
    vecs[1] = '{wb: 1'b1, wb_addr: 32'h200, fetch_addr: 32'h204,
                wb_data: 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
                exp_data: 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
                exp_lat: LAT_WB, hold: 0, early_rr: 1'b0};
    vecs[2] = '{wb: 1'b1, wb_addr: 32'h30C, fetch_addr: 32'h100,
                wb_data: 128'hB0000003_B0000002_B0000001_B0000000,
                exp_data: 128'h00000044_00000033_00000022_00000011,
                exp_lat: LAT_WB, hold: 5, early_rr: 1'b0};
    vecs[3] = '{wb: 1'b0, wb_addr: 32'h0, fetch_addr: 32'h304, wb_data: '0,
                exp_data: 128'hB0000003_B0000002_B0000001_B0000000,
                exp_lat: LAT_F, hold: 0, early_rr: 1'b1};
    vecs[4] = '{wb: 1'b0, wb_addr: 32'h0, fetch_addr: 32'h20F, wb_data: '0,
                exp_data: 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
                exp_lat: LAT_F, hold: 0, early_rr: 1'b0};

    // Reset for two cycles, then idle.
    rst = 1'b1;
    tick();
    ram_init = 1'b0;
    check_idle("reset c1");
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset resp_data", resp_data, 128'h0);
    tick();
    check_idle("reset c2");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("idle c%0d", i));
      check($sformatf("idle c%0d mem_addr", i), mem_addr, 32'h0);
    end
    $display("reset: req_ready=%0b busy=%0b resp_valid=%0b", req_ready, busy, resp_valid);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset in the middle of a write-back, at the start of beat 2.
    req_wb = 1'b1; req_wb_addr = 32'h400; req_fetch_addr = 32'h500;
    req_wb_data = 128'hC0000003_C0000002_C0000001_C0000000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2 * BEAT; i++) tick();
    check("midrst beat2 addr", mem_addr, 32'h408);
    check("midrst busy before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst after");
    check("midrst mem_addr", mem_addr, 32'h0);
    tick();
    check("midrst ram w0", ram[10'h100], 32'hC0000000);
    check("midrst ram w1", ram[10'h101], 32'hC0000001);
    check("midrst ram w2", ram[10'h102], 32'hDEAD0002);
    check("midrst ram w3", ram[10'h103], 32'hDEAD0003);
    $display("midrst: ram 0x400..0x40C = %h %h %h %h",
             ram[10'h100], ram[10'h101], ram[10'h102], ram[10'h103]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_block_ctrl.md
Name: mem_block_ctrl

Overview:
- Memory-side responder for the data cache's block refill/write-back interface.
- Accepts one request per transaction. A request is an optional dirty-block write-back plus a mandatory block fetch.
- Serialises each 128-bit block into word beats on a single-word backing RAM port, then returns the fetched block.
- Sits between the data cache and the word-wide data memory; replaces the current single-cycle block port.

Parameters:
- DATA_WIDTH, 32, word width of the backing RAM.
- ADDR_WIDTH, 32, byte address width.
- WORDS_PER_BLOCK, 4, words per cache block; must be a power of two.
- WAIT_STATES, 2, extra cycles per beat; used only when MEM_WAIT_STATES_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  cache presents a request.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_wb  in  1  request carries a dirty-block write-back.
- req_wb_addr  in  ADDR_WIDTH  write-back byte address; low offset bits ignored.
- req_wb_data  in  WORDS_PER_BLOCK*DATA_WIDTH  write-back block; word 0 in the LSBs.
- req_fetch_addr  in  ADDR_WIDTH  fetch byte address; low offset bits ignored.
- resp_valid  out  1  fetched block available.
- resp_ready  in  1  cache consumes the response.
- resp_data  out  WORDS_PER_BLOCK*DATA_WIDTH  fetched block; word 0 in the LSBs.
- busy  out  1  high whenever the state is not IDLE.
- mem_addr  out  ADDR_WIDTH  backing RAM byte address; always word aligned.
- mem_wr_en  out  1  backing RAM write strobe.
- mem_wdata  out  DATA_WIDTH  backing RAM write word.
- mem_rdata  in  DATA_WIDTH  backing RAM read word; valid one cycle after mem_addr is presented.

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready = 1, busy = 0, resp_valid = 0.
  - mem_wr_en = 0, mem_addr = 0, mem_wdata = 0, resp_data = 0.
  - Beat counter = 0.
- Reset mid-transaction: aborts immediately. No further writes are issued; partially written blocks are left as is.
- Block base address = addr with the low log2(WORDS_PER_BLOCK*4) bits cleared. Beat k uses base + 4*k, in ascending order k = 0..WORDS_PER_BLOCK-1.
- Accept:
  - A request is accepted on a cycle with req_valid & req_ready.
  - On acceptance the controller latches req_wb, both base addresses and req_wb_data.
  - Request inputs are don't-care afterwards.
- FSM states: IDLE, WB, FETCH, RESP.
- IDLE:
  - On accept, go to WB if req_wb=1, otherwise go to FETCH.
- WB (one cycle per beat):
  - Drive mem_wr_en = 1, mem_addr = wb_base + 4*k, mem_wdata = latched word k.
  - After beat WORDS_PER_BLOCK-1, go to FETCH; mem_wr_en drops.
- FETCH:
  - The counter runs 0..WORDS_PER_BLOCK.
  - At count k < WORDS_PER_BLOCK, drive mem_addr = fetch_base + 4*k with mem_wr_en = 0.
  - At count k > 0, capture mem_rdata into resp_data word k-1.
  - After count WORDS_PER_BLOCK, go to RESP.
- RESP:
  - resp_valid = 1 and resp_data is stable until the resp_ready cycle.
  - On resp_ready, go to IDLE the next cycle; req_ready rises in that cycle.
  - resp_data holds its value until the next FETCH overwrites it.
- Latency (macro off, WORDS_PER_BLOCK=4, accept at cycle T):
  - Fetch-only: resp_valid first at T+6.
  - With write-back: resp_valid first at T+10.
- Read-after-write: when a write-back and fetch target the same block, the fetch returns the just-written data, because all writes complete before the first read.
- req_valid while busy: ignored (req_ready=0). The cache must hold the request until it is accepted.
- resp_ready while resp_valid=0: no effect.
- The beat counter wraps to 0 on every state transition.

Optional Feature:
- Macro: MEM_WAIT_STATES_EN.
- Defined:
  - Each beat lasts 1+WAIT_STATES cycles; mem_addr is held for the whole beat.
  - WB: mem_wr_en is high only on the final cycle of each beat.
  - FETCH is not pipelined: mem_rdata is captured on the final cycle of each beat, and there is no trailing capture cycle.
  - Fetch-only latency = 1 + WORDS_PER_BLOCK*(1+WAIT_STATES) cycles to resp_valid. With WAIT_STATES=2 this is T+13.
- Undefined: single-cycle pipelined beats as specified above; WAIT_STATES is ignored.

Decomposition:
- Package mem_pkg holds:
  - The state enum typedef (IDLE, WB, FETCH, RESP).
  - The BLOCK_BYTES and OFFSET_BITS localparams derived from WORDS_PER_BLOCK.
  - A block typedef, logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0].
- One sub-module, mem_beat_ctr:
  - Beat index plus wait-state counter.
  - Inputs: clear, enable.
  - Outputs: beat, beat_last_cycle, beat_done.
  - The FSM stays in mem_block_ctrl.

Test Plan:
- Reset then idle:
  - rst high 2 cycles, low.
  - Required: req_ready=1, busy=0, resp_valid=0, mem_wr_en=0 throughout.
- Fetch-only:
  - RAM preloaded 0x100..0x10C = 0x11,0x22,0x33,0x44; req_fetch_addr=0x108, req_wb=0.
  - Required: mem_addr sequence 0x100,0x104,0x108,0x10C.
  - Required: resp_valid at T+6, resp_data = 0x00000044_00000033_00000022_00000011.
- Write-back then fetch, same block:
  - req_wb=1, wb_addr=0x200, data words A0..A3; fetch 0x204.
  - Required: 4 writes at T+1..T+4, resp_valid at T+10, resp_data equals written block.
- Response backpressure:
  - resp_ready low for 5 cycles.
  - Required: resp_valid and resp_data stable; req_ready=0; a new req_valid is not accepted.
  - Required: after resp_ready, req_ready=1 the next cycle.
- Reset mid write-back:
  - rst at beat 2.
  - Required: next cycle state IDLE, mem_wr_en=0; only words 0..1 written in RAM.
- MEM_WAIT_STATES_EN, WAIT_STATES=2:
  - Fetch-only request.
  - Required: mem_addr held 3 cycles per beat; resp_valid at T+13; data correct.
